// File: rtl/prog_mem_sequencer_pkg.sv
// Shared types and defaults for the program-memory fetch sequencer.
package pm_seq_pkg;

    localparam int PC_W_DEF      = 14;
    localparam int LPM_AW_DEF    = 15;
    localparam int IRQ_VEC_W_DEF = 5;
    localparam int CNT_W         = 2;   // wide enough for ROM_LAT up to 3

    typedef enum logic [2:0] {
        S_PRIME    = 3'd0,
        S_FETCH    = 3'd1,
        S_LPM_WAIT = 3'd2,
        S_LPM_DONE = 3'd3,
        S_FLUSH    = 3'd4
    } seq_state_t;

    // Interrupt vectors are two words apart: target PC = {index, 1'b0}.
    function automatic logic [31:0] vec_to_pc(input logic [31:0] vec);
        return {vec[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/pm_wait_counter.sv
// Loadable down-counter; done while the count sits at zero.
import pm_seq_pkg::*;

module pm_wait_counter #(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/prog_mem_sequencer.sv
// Program-memory fetch sequencer: arbitrates ROM port A between fetch and
// LPM reads, applies branch/interrupt redirects, holds fetch on stalls.
// Optional build macro PM_SEQ_IRQ_EN enables interrupt arbitration; without
// it the irq inputs are ignored and irq_ack / irq_ret_pc read as zero.
import pm_seq_pkg::*;

module prog_mem_sequencer #(
    parameter int PC_W      = PC_W_DEF,
    parameter int LPM_AW    = LPM_AW_DEF,
    parameter int ROM_LAT   = 1,
    parameter int IRQ_VEC_W = IRQ_VEC_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PC_W-1:0]      pc_cur,
    input  logic                 stall_req,
    input  logic                 br_req,
    input  logic [PC_W-1:0]      br_target,
    output logic                 br_ack,
    input  logic                 irq_req,
    input  logic [IRQ_VEC_W-1:0] irq_vec,
    input  logic                 irq_en,
    output logic                 irq_ack,
    output logic [PC_W-1:0]      irq_ret_pc,
    input  logic                 lpm_req,
    input  logic [LPM_AW-1:0]    lpm_addr_in,
    output logic                 lpm_ack,
    output logic [7:0]           lpm_data,
    input  logic [7:0]           pm_lpm_data,
    output logic                 pm_pc_inc,
    output logic                 pm_hold,
    output logic                 pm_pc_ovr,
    output logic [PC_W-1:0]      pm_pc_new,
    output logic                 pm_lpm_read,
    output logic [LPM_AW-1:0]    pm_lpm_addr,
    output logic                 instr_valid
);

    // Every counted state (LPM_WAIT, FLUSH) is entered with ROM_LAT-1 so it
    // lasts ROM_LAT cycles. PRIME starts with the counter at zero, so its
    // first cycle loads ROM_LAT-2 to cover the remaining cycles.
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0] PRIME_LOAD = (ROM_LAT > 1) ? CNT_W'(ROM_LAT - 2) : '0;

    seq_state_t        state, state_nxt;
    logic              prime_arm, prime_arm_set;
    logic              cnt_load, cnt_done;
    logic [CNT_W-1:0]  cnt_val;
    logic [LPM_AW-1:0] lpm_addr_q;
    logic              lpm_latch, lpm_cap;
    logic              irq_take, irq_ack_c;
    logic [PC_W-1:0]   irq_pc;

`ifdef PM_SEQ_IRQ_EN
    assign irq_take = irq_req & irq_en;
    assign irq_pc   = PC_W'(vec_to_pc(32'(irq_vec)));
`else
    logic unused_irq;
    assign unused_irq = ^{irq_req, irq_vec, irq_en, pc_cur};
    assign irq_take   = 1'b0;
    assign irq_pc     = '0;
`endif

    pm_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // State register plus the LPM address / result and prime-arm flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_PRIME;
            prime_arm  <= 1'b0;
            lpm_addr_q <= '0;
            lpm_data   <= '0;
            lpm_ack    <= 1'b0;
        end else begin
            state   <= state_nxt;
            lpm_ack <= lpm_cap;
            if (prime_arm_set)
                prime_arm <= 1'b1;
            if (lpm_latch)
                lpm_addr_q <= lpm_addr_in;
            if (lpm_cap)
                lpm_data <= pm_lpm_data;
        end
    end

`ifdef PM_SEQ_IRQ_EN
    // Return address is the PC at the moment the interrupt is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_ret_pc <= '0;
        else if (irq_ack_c)
            irq_ret_pc <= pc_cur;
    end
    assign irq_ack = irq_ack_c;
`else
    assign irq_ret_pc = '0;
    assign irq_ack    = 1'b0;
`endif

    // Next-state and program-memory controls; arbitration only in FETCH.
    always_comb begin
        state_nxt     = state;
        prime_arm_set = 1'b0;
        cnt_load      = 1'b0;
        cnt_val       = LAT_LOAD;
        lpm_latch     = 1'b0;
        lpm_cap       = 1'b0;
        irq_ack_c     = 1'b0;
        br_ack        = 1'b0;
        pm_pc_inc     = 1'b0;
        pm_hold       = 1'b0;
        pm_pc_ovr     = 1'b0;
        pm_pc_new     = '0;
        pm_lpm_read   = 1'b0;
        pm_lpm_addr   = '0;
        instr_valid   = 1'b0;
        case (state)
            S_PRIME: begin
                if (ROM_LAT <= 1 || (prime_arm && cnt_done)) begin
                    state_nxt = S_FETCH;
                end else if (!prime_arm) begin
                    prime_arm_set = 1'b1;
                    cnt_load      = 1'b1;
                    cnt_val       = PRIME_LOAD;
                end
            end
            S_FETCH: begin
                if (irq_take) begin
                    pm_pc_ovr = 1'b1;
                    pm_pc_new = irq_pc;
                    irq_ack_c = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (br_req) begin
                    pm_pc_ovr = 1'b1;
                    pm_pc_new = br_target;
                    br_ack    = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (lpm_req) begin
                    lpm_latch = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = S_LPM_WAIT;
                end else if (stall_req) begin
                    pm_hold     = 1'b1;
                    instr_valid = 1'b1;
                end else begin
                    pm_pc_inc   = 1'b1;
                    instr_valid = 1'b1;
                end
            end
            S_LPM_WAIT: begin
                pm_lpm_read = 1'b1;
                pm_lpm_addr = lpm_addr_q;
                if (cnt_done)
                    state_nxt = S_LPM_DONE;
            end
            S_LPM_DONE: begin
                // Result and ack are registered together, so the ack pulse
                // lands in the first FLUSH cycle alongside valid lpm_data.
                pm_lpm_read = 1'b1;
                pm_lpm_addr = lpm_addr_q;
                lpm_cap     = 1'b1;
                cnt_load    = 1'b1;
                state_nxt   = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt_done)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_PRIME;
        endcase
    end

endmodule

// File: tb/tb_prog_mem_sequencer.sv
// Directed bench for prog_mem_sequencer with a small program-memory model
// and an ack scoreboard.
module tb_prog_mem_sequencer;

    localparam int PC_W = 14;
    localparam int LPM_AW = 15;
    localparam int IRQ_VEC_W = 5;

    localparam int K_BR  = 0;
    localparam int K_IRQ = 1;
    localparam int K_LPM = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [PC_W-1:0]      pc_cur;
    logic                 stall_req, br_req, irq_req, irq_en, lpm_req;
    logic [PC_W-1:0]      br_target;
    logic [IRQ_VEC_W-1:0] irq_vec;
    logic [LPM_AW-1:0]    lpm_addr_in;
    logic                 br_ack, irq_ack, lpm_ack;
    logic [PC_W-1:0]      irq_ret_pc;
    logic [7:0]           lpm_data, pm_lpm_data;
    logic                 pm_pc_inc, pm_hold, pm_pc_ovr, pm_lpm_read, instr_valid;
    logic [PC_W-1:0]      pm_pc_new;
    logic [LPM_AW-1:0]    pm_lpm_addr;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    prog_mem_sequencer dut (
        .clk(clk), .reset_n(reset_n), .pc_cur(pc_cur), .stall_req(stall_req),
        .br_req(br_req), .br_target(br_target), .br_ack(br_ack),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_en(irq_en), .irq_ack(irq_ack),
        .irq_ret_pc(irq_ret_pc), .lpm_req(lpm_req), .lpm_addr_in(lpm_addr_in),
        .lpm_ack(lpm_ack), .lpm_data(lpm_data), .pm_lpm_data(pm_lpm_data),
        .pm_pc_inc(pm_pc_inc), .pm_hold(pm_hold), .pm_pc_ovr(pm_pc_ovr),
        .pm_pc_new(pm_pc_new), .pm_lpm_read(pm_lpm_read), .pm_lpm_addr(pm_lpm_addr),
        .instr_valid(instr_valid)
    );

    function automatic logic [7:0] rom_byte(input logic [LPM_AW-1:0] a);
        if (a == 15'h0041) return 8'h5A;
        return a[7:0] ^ 8'hA5;
    endfunction

    // Program-memory model: PC register and one-cycle LPM read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_cur      <= '0;
            pm_lpm_data <= '0;
        end else begin
            if (pm_pc_ovr)
                pc_cur <= pm_pc_new;
            else if (pm_pc_inc && !pm_hold)
                pc_cur <= pc_cur + 1'b1;
            if (pm_lpm_read)
                pm_lpm_data <= rom_byte(pm_lpm_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack pops one expectation; ovr/inc exclusive.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("ovr_inc_excl", 32'(pm_pc_ovr & pm_pc_inc), 32'd0);
            if (br_ack || irq_ack || lpm_ack) begin
                exp_t e;
                chk("one_ack", 32'($countones({br_ack, irq_ack, lpm_ack})), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({br_ack, irq_ack, lpm_ack}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_BR) begin
                        chk("sb_br_ack", 32'(br_ack), 32'd1);
                        chk("sb_br_pc_new", 32'(pm_pc_new), e.val);
                        chk("sb_br_ovr", 32'(pm_pc_ovr), 32'd1);
                    end else if (e.kind == K_IRQ) begin
                        chk("sb_irq_ack", 32'(irq_ack), 32'd1);
                        chk("sb_irq_pc_new", 32'(pm_pc_new), e.val);
                    end else begin
                        chk("sb_lpm_ack", 32'(lpm_ack), 32'd1);
                        chk("sb_lpm_data", 32'(lpm_data), e.val);
                    end
                end
            end
        end
    end

    initial begin
        logic [PC_W-1:0] pc0;
        reset_n = 1'b0;
        stall_req = 0; br_req = 0; irq_req = 0; irq_en = 0; lpm_req = 0;
        br_target = '0; irq_vec = '0; lpm_addr_in = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_pc_inc", 32'(pm_pc_inc), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_lpm_data", 32'(lpm_data), 0);
        chk("rst_ret_pc", 32'(irq_ret_pc), 0);
        chk("rst_lpm_read", 32'(pm_lpm_read), 0);
        reset_n = 1'b1;
        // PRIME: one cycle with no fetch
        chk("prime_valid", 32'(instr_valid), 0);
        chk("prime_inc", 32'(pm_pc_inc), 0);
        // Sequential fetch 0..3
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_pc", 32'(pc_cur), 32'(i));
            chk("seq_inc", 32'(pm_pc_inc), 1);
            chk("seq_valid", 32'(instr_valid), 1);
        end
        step(); step();
        chk("pc_at_5", 32'(pc_cur), 32'h5);
        // Branch
        br_req = 1; br_target = 14'h0123;
        exp_q.push_back('{K_BR, 32'h0123});
        #1;
        chk("br_ack", 32'(br_ack), 1);
        chk("br_no_inc", 32'(pm_pc_inc), 0);
        step();
        br_req = 0;
        chk("br_flush_valid", 32'(instr_valid), 0);
        chk("br_flush_ack", 32'(br_ack), 0);
        step();
        chk("br_resume_pc", 32'(pc_cur), 32'h0123);
        chk("br_resume_valid", 32'(instr_valid), 1);
        // LPM read
        pc0 = pc_cur;
        lpm_req = 1; lpm_addr_in = 15'h0041;
        exp_q.push_back('{K_LPM, 32'h5A});
        step();
        chk("lpm_wait_read", 32'(pm_lpm_read), 1);
        chk("lpm_wait_addr", 32'(pm_lpm_addr), 32'h0041);
        chk("lpm_wait_valid", 32'(instr_valid), 0);
        step();
        chk("lpm_done_read", 32'(pm_lpm_read), 1);
        chk("lpm_done_noack", 32'(lpm_ack), 0);
        step();
        chk("lpm_ack", 32'(lpm_ack), 1);
        chk("lpm_data", 32'(lpm_data), 32'h5A);
        chk("lpm_read_off", 32'(pm_lpm_read), 0);
        chk("lpm_pc_same", 32'(pc_cur), 32'(pc0));
        lpm_req = 0;
        step();
        chk("lpm_resume_valid", 32'(instr_valid), 1);
        chk("lpm_resume_pc", 32'(pc_cur), 32'(pc0));
        // Stall for three cycles
        pc0 = pc_cur;
        stall_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hold", 32'(pm_hold), 1);
            chk("stall_inc", 32'(pm_pc_inc), 0);
            chk("stall_pc", 32'(pc_cur), 32'(pc0));
            step();
        end
        stall_req = 0;
        #1;
        chk("stall_release_inc", 32'(pm_pc_inc), 1);
        step();
        // Interrupt and branch together
        pc0 = pc_cur;
        irq_req = 1; irq_vec = 5'd3; irq_en = 1; br_req = 1; br_target = 14'h0200;
`ifdef PM_SEQ_IRQ_EN
        exp_q.push_back('{K_IRQ, 32'h0006});
        #1;
        chk("irq_ack", 32'(irq_ack), 1);
        chk("irq_br_blocked", 32'(br_ack), 0);
        chk("irq_pc_new", 32'(pm_pc_new), 32'h0006);
        step();
        irq_req = 0;
        chk("irq_ret_pc", 32'(irq_ret_pc), 32'(pc0));
        chk("irq_flush_brack", 32'(br_ack), 0);
        exp_q.push_back('{K_BR, 32'h0200});
        step();
        chk("irq_vec_pc", 32'(pc_cur), 32'h0006);
        chk("br_after_irq", 32'(br_ack), 1);
        step();
        br_req = 0;
        step();
        chk("br_after_irq_pc", 32'(pc_cur), 32'h0200);
`else
        exp_q.push_back('{K_BR, 32'h0200});
        #1;
        chk("irqoff_ack", 32'(irq_ack), 0);
        chk("irqoff_br_ack", 32'(br_ack), 1);
        step();
        irq_req = 0; br_req = 0;
        chk("irqoff_ret_pc", 32'(irq_ret_pc), 0);
        step();
        chk("irqoff_br_pc", 32'(pc_cur), 32'h0200);
`endif
        // Reset during LPM_WAIT
        lpm_req = 1; lpm_addr_in = 15'h0010;
        step();
        chk("rlpm_read", 32'(pm_lpm_read), 1);
        #2;
        reset_n = 0;
        #1;
        chk("rlpm_read_off", 32'(pm_lpm_read), 0);
        chk("rlpm_no_ack", 32'(lpm_ack), 0);
        chk("rlpm_valid", 32'(instr_valid), 0);
        lpm_req = 0;
        step();
        reset_n = 1;
        chk("rlpm_prime_valid", 32'(instr_valid), 0);
        step();
        chk("rlpm_fetch_pc", 32'(pc_cur), 0);
        chk("rlpm_fetch_valid", 32'(instr_valid), 1);
        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
